thread_scheduler: RTL and testbench



---
 rtl/thread_scheduler_if.sv | 28 ++
 rtl/thread_scheduler.sv | 139 +++++++++++++
 tb/tb_thread_scheduler.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/thread_scheduler_if.sv
// Scheduler bus: thread enables, stall requests, pipeline stall and issue outputs.
interface thread_scheduler_if #(
   parameter int unsigned THREAD_BITS     = 2,
   parameter int unsigned NUM_THREADS     = 4,
   parameter int unsigned STALL_CNT_WIDTH = 4
);
   logic [NUM_THREADS-1:0]     thread_en;
   logic                       pipe_stall;
   logic                       stall_req_valid;
   logic [THREAD_BITS-1:0]     stall_req_tid;
   logic [STALL_CNT_WIDTH-1:0] stall_req_cycles;
   logic                       pipe_en;
   logic                       issue_valid;
   logic [THREAD_BITS-1:0]     issue_tid;
   logic [NUM_THREADS-1:0]     thread_ready;

   // Driver side (pipeline control / testbench).
   modport master (
      output thread_en, pipe_stall, stall_req_valid, stall_req_tid, stall_req_cycles,
      input  pipe_en, issue_valid, issue_tid, thread_ready
   );

   // Scheduler side.
   modport slave (
      input  thread_en, pipe_stall, stall_req_valid, stall_req_tid, stall_req_cycles,
      output pipe_en, issue_valid, issue_tid, thread_ready
   );
endinterface

// File: rtl/thread_scheduler.sv
// Fine-grained round-robin thread scheduler: tracks per-thread OFF/READY/STALLED
// state and issues one ready thread ID per cycle unless the pipeline is stalled.
module thread_scheduler #(
   parameter int unsigned THREAD_BITS     = 2,
   parameter int unsigned NUM_THREADS     = 4,
   parameter int unsigned STALL_CNT_WIDTH = 4
) (
   input  logic                clk,
   input  logic                reset,
   thread_scheduler_if.slave   bus
);

   typedef enum logic [1:0] {
      TS_OFF     = 2'd0,
      TS_READY   = 2'd1,
      TS_STALLED = 2'd2
   } tstate_e;

   tstate_e                    state_q [NUM_THREADS];
   tstate_e                    state_d [NUM_THREADS];
   logic [STALL_CNT_WIDTH-1:0] cnt_q   [NUM_THREADS];
   logic [STALL_CNT_WIDTH-1:0] cnt_d   [NUM_THREADS];

   logic [THREAD_BITS-1:0]     ptr_q, ptr_d;
   logic                       issue_valid_q, issue_valid_d;
   logic [THREAD_BITS-1:0]     issue_tid_q, issue_tid_d;
   logic [NUM_THREADS-1:0]     thread_ready_q, thread_ready_d;

   logic [NUM_THREADS-1:0]     req_sel;
   logic [NUM_THREADS-1:0]     cand;
   logic                       found;
   logic [THREAD_BITS-1:0]     winner;

   // Decode the stall request target and build the issue candidate mask.
   always_comb begin
      req_sel = '0;
      cand    = '0;
      if (bus.stall_req_valid) begin
         req_sel[bus.stall_req_tid] = 1'b1;
      end
      for (int i = 0; i < NUM_THREADS; i++) begin
         cand[i] = (state_q[i] == TS_READY) && !req_sel[i];
      end
   end

   // Round-robin search starting one past the last issued thread.
   always_comb begin
      found  = 1'b0;
      winner = ptr_q;
      for (int k = 1; k <= NUM_THREADS; k++) begin
         if (!found && cand[THREAD_BITS'(ptr_q + THREAD_BITS'(k))]) begin
            found  = 1'b1;
            winner = THREAD_BITS'(ptr_q + THREAD_BITS'(k));
         end
      end
   end

   // Per-thread next state: disable wins, then stall request, then countdown.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      for (int i = 0; i < NUM_THREADS; i++) begin
         if (!bus.thread_en[i]) begin
            state_d[i] = TS_OFF;
            cnt_d[i]   = '0;
         end else begin
            unique case (state_q[i])
               TS_OFF: begin
                  state_d[i] = TS_READY;
               end
               TS_READY: begin
                  if (req_sel[i] && (bus.stall_req_cycles != '0)) begin
                     state_d[i] = TS_STALLED;
                     cnt_d[i]   = bus.stall_req_cycles;
                  end
               end
               TS_STALLED: begin
                  if (req_sel[i] && (bus.stall_req_cycles != '0)) begin
                     cnt_d[i] = bus.stall_req_cycles;
                  end else if (cnt_q[i] == STALL_CNT_WIDTH'(1)) begin
                     state_d[i] = TS_READY;
                     cnt_d[i]   = '0;
                  end else begin
                     cnt_d[i] = cnt_q[i] - STALL_CNT_WIDTH'(1);
                  end
               end
               default: begin
                  state_d[i] = TS_OFF;
                  cnt_d[i]   = '0;
               end
            endcase
         end
      end
   end

   // Issue slot and pointer hold while the pipeline is stalled.
   always_comb begin
      issue_valid_d = issue_valid_q;
      issue_tid_d   = issue_tid_q;
      ptr_d         = ptr_q;
      if (!bus.pipe_stall) begin
         issue_valid_d = found;
         if (found) begin
            issue_tid_d = winner;
            ptr_d       = winner;
         end
      end
      for (int i = 0; i < NUM_THREADS; i++) begin
         thread_ready_d[i] = (state_d[i] == TS_READY);
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_THREADS; i++) begin
            state_q[i] <= TS_OFF;
            cnt_q[i]   <= '0;
         end
         ptr_q          <= THREAD_BITS'(NUM_THREADS - 1);
         issue_valid_q  <= 1'b0;
         issue_tid_q    <= '0;
         thread_ready_q <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         ptr_q          <= ptr_d;
         issue_valid_q  <= issue_valid_d;
         issue_tid_q    <= issue_tid_d;
         thread_ready_q <= thread_ready_d;
      end
   end

   assign bus.pipe_en      = ~bus.pipe_stall;
   assign bus.issue_valid  = issue_valid_q;
   assign bus.issue_tid    = issue_tid_q;
   assign bus.thread_ready = thread_ready_q;

endmodule

// File: tb/tb_thread_scheduler.sv
// Testbench for thread_scheduler: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a resume-time model.
module tb_thread_scheduler;

   localparam int unsigned TB = 2;
   localparam int unsigned NT = 4;
   localparam int unsigned SW = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   thread_scheduler_if #(.THREAD_BITS(TB), .NUM_THREADS(NT), .STALL_CNT_WIDTH(SW)) bus ();

   thread_scheduler #(.THREAD_BITS(TB), .NUM_THREADS(NT), .STALL_CNT_WIDTH(SW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: a thread is READY after edge e when enabled and its resume edge <= e.
   bit          m_live = 1'b0;
   bit          m_on     [NT];
   int          m_resume [NT];
   int          m_edge;
   bit          m_iv;
   int          m_tid;
   int          m_ptr;
   bit [NT-1:0] m_ready;
   bit [NT-1:0] m_cand;
   bit          m_found;
   int          m_win;
   int          m_e;
   int          m_t;

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NT; i++) begin
            m_on[i]     = 1'b0;
            m_resume[i] = 0;
         end
         m_iv    = 1'b0;
         m_tid   = 0;
         m_ptr   = NT - 1;
         m_ready = '0;
         m_edge  = 0;
         m_live  = 1'b1;
      end else if (m_live) begin
         m_e = m_edge + 1;
         for (int i = 0; i < NT; i++) begin
            m_cand[i] = m_on[i] && (m_resume[i] <= m_e - 1) &&
                        !(bus.stall_req_valid && (int'(bus.stall_req_tid) == i));
         end
         m_found = 1'b0;
         m_win   = 0;
         for (int k = 1; k <= NT; k++) begin
            m_t = (m_ptr + k) % NT;
            if (!m_found && m_cand[m_t]) begin
               m_found = 1'b1;
               m_win   = m_t;
            end
         end
         if (!bus.pipe_stall) begin
            m_iv = m_found;
            if (m_found) begin
               m_tid = m_win;
               m_ptr = m_win;
            end
         end
         for (int i = 0; i < NT; i++) begin
            if (!bus.thread_en[i]) begin
               m_on[i] = 1'b0;
            end else if (!m_on[i]) begin
               m_on[i]     = 1'b1;
               m_resume[i] = m_e;
            end else if (bus.stall_req_valid && (int'(bus.stall_req_tid) == i) &&
                         (bus.stall_req_cycles != '0)) begin
               m_resume[i] = m_e + int'(bus.stall_req_cycles);
            end
         end
         for (int i = 0; i < NT; i++) begin
            m_ready[i] = m_on[i] && (m_resume[i] <= m_e);
         end
         m_edge = m_e;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (m_live) begin
         chk("model issue_valid",  32'(bus.issue_valid),  32'(m_iv));
         chk("model issue_tid",    32'(bus.issue_tid),    32'(m_tid));
         chk("model thread_ready", 32'(bus.thread_ready), 32'(m_ready));
         chk("model pipe_en",      32'(bus.pipe_en),      32'(!bus.pipe_stall));
      end
   end

   task automatic drive(input logic [NT-1:0] en, input logic ps, input logic rv,
                        input int rt, input int rc);
      bus.thread_en        = en;
      bus.pipe_stall       = ps;
      bus.stall_req_valid  = rv;
      bus.stall_req_tid    = TB'(rt);
      bus.stall_req_cycles = SW'(rc);
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic exp_issue(input string name, input logic v, input int tid);
      chk({name, " valid"}, 32'(bus.issue_valid), 32'(v));
      chk({name, " tid"},   32'(bus.issue_tid),   32'(tid));
   endtask

   task automatic do_reset(input logic [NT-1:0] en_after);
      reset = 1'b1;
      drive('0, 1'b0, 1'b0, 0, 0);
      tick();
      reset = 1'b0;
      drive(en_after, 1'b0, 1'b0, 0, 0);
   endtask

   int          seq1 [5] = '{0, 1, 2, 3, 0};
   int          seq2 [4] = '{0, 2, 0, 2};
   int          seq3 [3] = '{0, 1, 2};
   int          seq4 [6] = '{3, 0, 2, 3, 0, 1};
   logic [NT-1:0] ren;

   initial begin
      drive('0, 1'b0, 1'b0, 0, 0);
      reset = 1'b1;
      tick();
      tick();
      exp_issue("reset", 1'b0, 0);
      chk("reset thread_ready", 32'(bus.thread_ready), 32'h0);

      // All enabled: first edge readies, then 0,1,2,3,0.
      reset = 1'b0;
      drive(4'b1111, 1'b0, 1'b0, 0, 0);
      tick();
      chk("rr first-edge valid", 32'(bus.issue_valid), 32'h0);
      chk("rr first-edge ready", 32'(bus.thread_ready), 32'hF);
      for (int i = 0; i < 5; i++) begin
         tick();
         exp_issue("rr all", 1'b1, seq1[i]);
      end

      // Mask 0101, then thread 1 joins.
      do_reset(4'b0101);
      tick();
      chk("mask ready", 32'(bus.thread_ready), 32'h5);
      for (int i = 0; i < 4; i++) begin
         tick();
         exp_issue("mask 0101", 1'b1, seq2[i]);
      end
      drive(4'b0111, 1'b0, 1'b0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         exp_issue("join thread1", 1'b1, seq3[i]);
      end

      // Stall thread 1 for 3 cycles in the cycle it would win.
      do_reset(4'b1111);
      tick();
      tick();
      exp_issue("stall1 pre", 1'b1, 0);
      drive(4'b1111, 1'b0, 1'b1, 1, 3);
      tick();
      exp_issue("stall1 skip", 1'b1, 2);
      drive(4'b1111, 1'b0, 1'b0, 0, 0);
      for (int i = 0; i < 6; i++) begin
         tick();
         exp_issue("stall1 seq", 1'b1, seq4[i]);
         if (i == 1) chk("stall1 ready E", 32'(bus.thread_ready), 32'hD);
         if (i == 2) chk("stall1 ready F", 32'(bus.thread_ready), 32'hF);
      end

      // Pipe stall while thread 2 counts down.
      do_reset(4'b1111);
      tick();
      tick();
      tick();
      exp_issue("pstall pre", 1'b1, 1);
      drive(4'b1111, 1'b0, 1'b1, 2, 3);
      tick();
      exp_issue("pstall D", 1'b1, 3);
      drive(4'b1111, 1'b0, 1'b0, 0, 0);
      tick();
      exp_issue("pstall E", 1'b1, 0);
      drive(4'b1111, 1'b1, 1'b0, 0, 0);
      tick();
      exp_issue("pstall frozen F", 1'b1, 0);
      chk("pstall pipe_en", 32'(bus.pipe_en), 32'h0);
      chk("pstall ready F", 32'(bus.thread_ready), 32'hB);
      tick();
      exp_issue("pstall frozen G", 1'b1, 0);
      chk("pstall ready G", 32'(bus.thread_ready), 32'hF);
      drive(4'b1111, 1'b0, 1'b0, 0, 0);
      tick();
      exp_issue("pstall H", 1'b1, 1);
      tick();
      exp_issue("pstall I", 1'b1, 2);

      // All enabled threads stalled: bubbles, tid holds, restart at ptr+1.
      do_reset(4'b0011);
      tick();
      tick();
      tick();
      exp_issue("allstall C", 1'b1, 1);
      drive(4'b0011, 1'b0, 1'b1, 0, 4);
      tick();
      exp_issue("allstall D", 1'b1, 1);
      drive(4'b0011, 1'b0, 1'b1, 1, 4);
      tick();
      exp_issue("allstall E", 1'b0, 1);
      drive(4'b0011, 1'b0, 1'b0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         exp_issue("allstall bubble", 1'b0, 1);
      end
      chk("allstall ready H", 32'(bus.thread_ready), 32'h1);
      tick();
      exp_issue("allstall I", 1'b1, 0);
      tick();
      exp_issue("allstall J", 1'b1, 1);

      // Reset while thread 3 is stalled.
      do_reset(4'b1111);
      for (int i = 0; i < 4; i++) tick();
      exp_issue("rst3 pre", 1'b1, 2);
      drive(4'b1111, 1'b0, 1'b1, 3, 7);
      tick();
      exp_issue("rst3 E", 1'b1, 0);
      drive(4'b1111, 1'b0, 1'b0, 0, 0);
      tick();
      reset = 1'b1;
      tick();
      exp_issue("rst3 reset", 1'b0, 0);
      chk("rst3 reset ready", 32'(bus.thread_ready), 32'h0);
      reset = 1'b0;
      drive(4'b1000, 1'b0, 1'b0, 0, 0);
      tick();
      exp_issue("rst3 H", 1'b0, 0);
      chk("rst3 ready H", 32'(bus.thread_ready), 32'h8);
      tick();
      exp_issue("rst3 I", 1'b1, 3);

      // Randomized traffic, checked by the per-cycle model comparison.
      ren = 4'b1111;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 15) == 0) ren = NT'($urandom) | NT'($urandom);
         reset = ($urandom_range(0, 199) == 0);
         drive(ren, ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0),
               int'($urandom_range(0, NT - 1)), int'($urandom_range(0, 15)));
         tick();
      end
      reset = 1'b0;
      drive('0, 1'b0, 1'b0, 0, 0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
